// File: rtl/led_panel_pkg.sv
// Shared opcodes, FSM state encoding and frame-store geometry for the LED-panel
// command sequencer.
package led_panel_pkg;

    localparam int NCOLS_DEFAULT = 16;

    // COLOR and COL carry an operand in their low bits.
    localparam logic [7:0] OP_COLOR  = 8'h80;
    localparam logic [7:0] OP_COL    = 8'h90;
    localparam logic [7:0] OP_CLEAR  = 8'hA0;
    localparam logic [7:0] OP_BULK   = 8'hB0;
    localparam logic [7:0] OP_COMMIT = 8'hC0;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        BULK,
        CLEAR,
        WAIT_SYNC,
        COPY
    } state_e;

endpackage

// File: rtl/led_panel_cmd_ctrl_if.sv
// Byte intake, frame-store and scanner-facing signals of the command sequencer.
interface led_panel_cmd_ctrl_if #(
    parameter int AW = 4
);
    logic          rx_dv;
    logic [7:0]    rx_data;
    logic          frame_sync;
    logic          fb_wr_en;
    logic          fb_wr_bank;
    logic [AW-1:0] fb_wr_addr;
    logic [7:0]    fb_wr_data;
    logic [AW-1:0] fb_rd_addr;
    logic [7:0]    fb_rd_data;
    logic          fb_front;
    logic [2:0]    rgb;
    logic          busy;
    logic          overrun;
    logic          cmd_error;

    modport slave (
        input  rx_dv, rx_data, frame_sync, fb_rd_data,
        output fb_wr_en, fb_wr_bank, fb_wr_addr, fb_wr_data, fb_rd_addr,
               fb_front, rgb, busy, overrun, cmd_error
    );

    modport master (
        output rx_dv, rx_data, frame_sync, fb_rd_data,
        input  fb_wr_en, fb_wr_bank, fb_wr_addr, fb_wr_data, fb_rd_addr,
               fb_front, rgb, busy, overrun, cmd_error
    );
endinterface

// File: rtl/led_panel_byte_hold.sv
// One-entry intake buffer. While the consumer accepts, a held byte wins over a
// fresh one, which then takes its place; otherwise a fresh byte is parked or lost.
module led_panel_byte_hold (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       overrun_o
);
    logic       full_q, full_d;
    logic [7:0] data_q, data_d;
    logic       ovr_q, ovr_d;

    assign valid_o   = full_q | push_i;
    assign data_o    = full_q ? data_q : push_data_i;
    assign overrun_o = ovr_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ovr_d  = ovr_q;
        if (pop_i) begin
            full_d = full_q & push_i;
            if (full_q && push_i) begin
                data_d = push_data_i;
            end
        end else if (push_i) begin
            if (!full_q) begin
                full_d = 1'b1;
                data_d = push_data_i;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
            ovr_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            ovr_q  <= ovr_d;
        end
    end
endmodule

// File: rtl/led_panel_cmd_ctrl.sv
// Command sequencer between uart_rx and a double-buffered 16x8 LED frame store:
// edits go to the back bank, COMMIT swaps on frame_sync and copies front->back.
module led_panel_cmd_ctrl
    import led_panel_pkg::*;
#(
    parameter int         NCOLS     = NCOLS_DEFAULT,
    parameter logic [2:0] RGB_RESET = 3'b101
) (
    input logic                  clk,
    input logic                  reset,
    led_panel_cmd_ctrl_if.slave  bus
);
    localparam int AW = $clog2(NCOLS);
    localparam logic [AW:0] LAST_COL = (AW+1)'(NCOLS - 1);
    localparam logic [AW:0] COPY_END = (AW+1)'(NCOLS);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          front_q, front_d;
    logic [2:0]    rgb_q, rgb_d;
    logic          err_q, err_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic       accept, take, byte_vld, ovr;
    logic [7:0] byte_data;
    logic       is_color, is_col, is_clear, is_bulk, is_commit;

    assign accept = state_q inside {IDLE, ARG, BULK};
    assign take   = accept & byte_vld;

    led_panel_byte_hold u_hold (
        .clk        (clk),
        .reset      (reset),
        .push_i     (bus.rx_dv),
        .push_data_i(bus.rx_data),
        .pop_i      (accept),
        .valid_o    (byte_vld),
        .data_o     (byte_data),
        .overrun_o  (ovr)
    );

    assign is_color  = byte_data[7:3] == OP_COLOR[7:3];
    assign is_col    = byte_data[7:4] == OP_COL[7:4];
    assign is_clear  = byte_data == OP_CLEAR;
    assign is_bulk   = byte_data == OP_BULK;
    assign is_commit = byte_data == OP_COMMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            front_q   <= 1'b0;
            rgb_q     <= RGB_RESET;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            front_q   <= front_d;
            rgb_q     <= rgb_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // cnt_q is the target column in ARG/BULK/CLEAR and the copy cycle in COPY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (is_col) begin
                        state_d = ARG;
                        cnt_d   = (AW+1)'(byte_data[3:0]);
                    end else if (is_clear) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else if (is_bulk) begin
                        state_d = BULK;
                        cnt_d   = '0;
                    end else if (is_commit) begin
                        state_d = WAIT_SYNC;
                    end
                end
            end
            ARG: begin
                if (take) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            BULK: begin
                if (take) begin
                    if (cnt_q == LAST_COL) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_COL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_SYNC: begin
                if (bus.frame_sync) begin
                    state_d = COPY;
                    cnt_d   = '0;
                end
            end
            COPY: begin
                if (cnt_q == COPY_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = cnt_q[AW-1:0];
        wr_data_d = byte_data;
        rgb_d     = rgb_q;
        err_d     = err_q;
        front_d   = front_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    if (is_color) begin
                        rgb_d = byte_data[2:0];
                    end else if (!(is_col || is_clear || is_bulk || is_commit)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ARG, BULK: wr_en_d = take;
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_data_d = 8'h00;
            end
            WAIT_SYNC: begin
                if (bus.frame_sync) begin
                    front_d = ~front_q;
                end
            end
            COPY: begin
                // Read data lags its address by one cycle, so write column cnt-1.
                if (cnt_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(cnt_q - 1'b1);
                    wr_data_d = bus.fb_rd_data;
                end
            end
            default: wr_en_d = 1'b0;
        endcase
    end

    assign bus.fb_wr_en   = wr_en_q;
    assign bus.fb_wr_bank = ~front_q;
    assign bus.fb_wr_addr = wr_addr_q;
    assign bus.fb_wr_data = wr_data_q;
    assign bus.fb_rd_addr = (state_q == COPY) ? cnt_q[AW-1:0] : '0;
    assign bus.fb_front   = front_q;
    assign bus.rgb        = rgb_q;
    assign bus.busy       = state_q inside {CLEAR, WAIT_SYNC, COPY};
    assign bus.overrun    = ovr;
    assign bus.cmd_error  = err_q;
endmodule

// File: tb/tb_led_panel_cmd_ctrl.sv
// Bench for led_panel_cmd_ctrl: a write scoreboard fed by the stimulus and drained
// by a monitor, plus a behavioural two-bank frame store with registered read.
module tb_led_panel_cmd_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_panel_cmd_ctrl_if #(.AW(4)) bus ();

    led_panel_cmd_ctrl #(.NCOLS(16), .RGB_RESET(3'b101)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic       bank;
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_count = 0;

    logic [7:0] mem [2][16];

    always @(posedge clk) begin
        if (bus.fb_wr_en) mem[bus.fb_wr_bank][bus.fb_wr_addr] <= bus.fb_wr_data;
        bus.fb_rd_data <= mem[bus.fb_front][bus.fb_rd_addr];
    end

    function automatic wr_t mk(bit b, int a, int d);
        wr_t w;
        w.bank = b;
        w.addr = 4'(a);
        w.data = 8'(d);
        return w;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b);
        bus.rx_dv   = 1'b1;
        bus.rx_data = b;
        tick();
        bus.rx_dv   = 1'b0;
    endtask

    task automatic drain(string name);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Write monitor: every frame-store write must match the next expected one.
    initial begin
        wr_t got;
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.fb_wr_en === 1'b1) begin
                wr_count++;
                got.bank = bus.fb_wr_bank;
                got.addr = bus.fb_wr_addr;
                got.data = bus.fb_wr_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {19'd0, got}, 32'h1fff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("write{bank,addr,data}", {19'd0, got}, {19'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.rx_dv      = 1'b0;
        bus.rx_data    = 8'h00;
        bus.frame_sync = 1'b0;
        tick(3);
        reset = 1'b0;

        // Reset state, idle for 20 cycles.
        tick(20);
        check("reset_no_write", wr_count, 0);
        check("reset_rgb", bus.rgb, 3'b101);
        check("reset_front", bus.fb_front, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_overrun", bus.overrun, 0);
        check("reset_cmd_error", bus.cmd_error, 0);

        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        check("sync_ignored_idle", bus.fb_front, 0);

        // Single column write.
        exp_q.push_back(mk(1, 3, 8'hA5));
        send(8'h93);
        send(8'hA5);
        check("col_wr_latency", bus.fb_wr_en, 1);
        tick();
        check("col_wr_one_cycle", bus.fb_wr_en, 0);
        check("col_idle", bus.busy, 0);
        check("col_wr_count", wr_count, 1);

        // Bulk load with data bytes that are not opcodes, then a colour command.
        for (int k = 0; k < 16; k++) exp_q.push_back(mk(1, k, k));
        send(8'hB0);
        for (int k = 0; k < 16; k++) send(8'(k));
        send(8'h82);
        check("bulk_then_rgb", bus.rgb, 3'b010);
        drain("bulk_drain");
        check("bulk_wr_count", wr_count, 17);

        // Commit: swap on frame_sync, copy new front (bank1) into bank0.
        for (int k = 0; k < 16; k++) exp_q.push_back(mk(0, k, k));
        send(8'hC0);
        check("commit_busy", bus.busy, 1);
        tick(50);
        check("front_before_sync", bus.fb_front, 0);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        check("front_swap", bus.fb_front, 1);
        tick(16);
        check("copy_busy_cycle16", bus.busy, 1);
        tick();
        check("copy_done_cycle17", bus.busy, 0);
        drain("copy_drain");
        check("copy_wr_count", wr_count, 33);

        // Clear with two bytes arriving while busy: first held, second lost.
        for (int k = 0; k < 16; k++) exp_q.push_back(mk(0, k, 0));
        send(8'hA0);
        check("clear_busy", bus.busy, 1);
        send(8'h84);
        check("hold_no_overrun", bus.overrun, 0);
        send(8'h85);
        check("overrun_set", bus.overrun, 1);
        tick(20);
        check("held_byte_rgb", bus.rgb, 3'b100);
        check("clear_idle", bus.busy, 0);
        drain("clear_drain");
        check("clear_wr_count", wr_count, 49);

        // Reset while waiting for sync abandons the commit.
        send(8'hC0);
        check("commit2_busy", bus.busy, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        tick(20);
        check("rst_front", bus.fb_front, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun_clr", bus.overrun, 0);
        check("rst_rgb", bus.rgb, 3'b101);
        check("rst_no_copy", wr_count, 49);
        check("cmd_error_before", bus.cmd_error, 0);
        send(8'hFF);
        check("cmd_error_set", bus.cmd_error, 1);
        tick(5);
        check("cmd_error_sticky", bus.cmd_error, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
